// File: rtl/fmul_wb_buffer.sv
// Multiplier result stage: special-case fixup, 2-entry writeback FIFO, sticky flags, retired count.
// Latency: a result pushed at edge N is presented on wb_* after edge N and can be popped at edge N+1.
// Backpressure: in_ready = !full and is registered-only (no path from wb_ready); wb_* hold while stalled.
module fmul_wb_buffer #(
   parameter int DEPTH = 2,   // only 2 is supported: pointers are 1 bit wide
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_product,
   input  logic             in_invalid,
   input  logic             in_ovf_dir,
   input  logic             in_zero,
   input  logic [4:0]       in_rd,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [31:0]      wb_data,
   output logic [4:0]       wb_rd,
   output logic             flag_ovf,
   output logic             flag_unf,
   input  logic             flag_clr,
   output logic [CNT_W-1:0] retired
);

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   logic [31:0]      data_q [2];
   logic [31:0]      data_d [2];
   logic [4:0]       tag_q  [2];
   logic [4:0]       tag_d  [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             flag_ovf_q, flag_ovf_d;
   logic             flag_unf_q, flag_unf_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic [31:0]      fix_data;
   logic             fix_ovf;
   logic             fix_unf;
   logic             push;
   logic             pop;

   // Status outputs come straight from state so in_ready never depends on wb_ready.
   assign in_ready = (count_q != FULL_CNT);
   assign wb_valid = (count_q != 2'd0);
   assign wb_data  = wb_valid ? data_q[rd_ptr_q] : 32'd0;
   assign wb_rd    = wb_valid ? tag_q[rd_ptr_q]  : 5'd0;
   assign flag_ovf = flag_ovf_q;
   assign flag_unf = flag_unf_q;
   assign retired  = retired_q;

   assign push = in_valid && in_ready;
   assign pop  = wb_valid && wb_ready;

   // Special-case fixup; a zero operand masks any exponent range error and raises no flag.
   always_comb begin
      fix_data = in_product;
      fix_ovf  = 1'b0;
      fix_unf  = 1'b0;
      if (in_zero) begin
         fix_data = {in_product[31], 31'b0};
      end else if (in_invalid) begin
         if (in_ovf_dir) begin
            fix_data = {in_product[31], 8'hFF, 23'b0};
            fix_ovf  = 1'b1;
         end else begin
            fix_data = {in_product[31], 31'b0};
            fix_unf  = 1'b1;
         end
      end
   end

   // Next-state for FIFO storage, pointers, occupancy, sticky flags and retired counter.
   always_comb begin
      data_d     = data_q;
      tag_d      = tag_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      flag_ovf_d = flag_ovf_q;
      flag_unf_d = flag_unf_q;
      retired_d  = retired_q;

      if (push) begin
         data_d[wr_ptr_q] = fix_data;
         tag_d[wr_ptr_q]  = in_rd;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d  = ~rd_ptr_q;
         retired_d = retired_q + CNT_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      // Clear first so a same-cycle set overrides it.
      if (flag_clr) begin
         flag_ovf_d = 1'b0;
         flag_unf_d = 1'b0;
      end
      if (push && fix_ovf) flag_ovf_d = 1'b1;
      if (push && fix_unf) flag_unf_d = 1'b1;
   end

   // State registers; reset discards queued entries immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q[0]  <= 32'd0;
         data_q[1]  <= 32'd0;
         tag_q[0]   <= 5'd0;
         tag_q[1]   <= 5'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         flag_ovf_q <= 1'b0;
         flag_unf_q <= 1'b0;
         retired_q  <= '0;
      end else begin
         data_q     <= data_d;
         tag_q      <= tag_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         flag_ovf_q <= flag_ovf_d;
         flag_unf_q <= flag_unf_d;
         retired_q  <= retired_d;
      end
   end

endmodule

// File: tb/tb_fmul_wb_buffer.sv
// Directed bench for fmul_wb_buffer.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants plus a running count of pops.
module tb_fmul_wb_buffer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_product;
   logic        in_invalid;
   logic        in_ovf_dir;
   logic        in_zero;
   logic [4:0]  in_rd;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        flag_ovf;
   logic        flag_unf;
   logic        flag_clr;
   logic [15:0] retired;

   int errors;
   int checks;
   logic [15:0] exp_ret;

   fmul_wb_buffer #(.DEPTH(2), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .in_invalid (in_invalid),
      .in_ovf_dir (in_ovf_dir),
      .in_zero    (in_zero),
      .in_rd      (in_rd),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_data    (wb_data),
      .wb_rd      (wb_rd),
      .flag_ovf   (flag_ovf),
      .flag_unf   (flag_unf),
      .flag_clr   (flag_clr),
      .retired    (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] p, input logic inv,
                        input logic dir, input logic z, input logic [4:0] rd);
      in_valid   = v;
      in_product = p;
      in_invalid = inv;
      in_ovf_dir = dir;
      in_zero    = z;
      in_rd      = rd;
   endtask

   task automatic idle();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic test_reset();
      idle();
      wb_ready = 1'b0;
      flag_clr = 1'b0;
      reset    = 1'b1;
      #12;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
      checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
      checks++; if ({flag_ovf, flag_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {flag_ovf, flag_unf}); end
      checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
      @(negedge clk);
      reset = 1'b0;
      step();
      exp_ret = 16'd0;
   endtask

   task automatic test_normal();
      wb_ready = 1'b1;
      drive(1'b1, 32'h40C00000, 1'b0, 1'b0, 1'b0, 5'd3);
      step();
      idle();
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL normal_valid: got %0b want 1", wb_valid); end
      checks++; if (wb_data !== 32'h40C00000) begin errors++; $display("FAIL normal_data: got %h want 40c00000", wb_data); end
      checks++; if (wb_rd !== 5'd3) begin errors++; $display("FAIL normal_rd: got %0d want 3", wb_rd); end
      step();
      exp_ret = exp_ret + 16'd1;
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL normal_retired: got %0d want %0d", retired, exp_ret); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL normal_drained: got %0b want 0", wb_valid); end
      checks++; if ({flag_ovf, flag_unf} !== 2'b00) begin errors++; $display("FAIL normal_flags: got %b want 00", {flag_ovf, flag_unf}); end
   endtask

   task automatic test_fixups();
      // zero operand: sign kept, magnitude cleared, no flag
      wb_ready = 1'b0;
      drive(1'b1, 32'hBF800000, 1'b0, 1'b0, 1'b1, 5'd9);
      step();
      idle();
      checks++; if (wb_data !== 32'h80000000) begin errors++; $display("FAIL zero_data: got %h want 80000000", wb_data); end
      checks++; if ({flag_ovf, flag_unf} !== 2'b00) begin errors++; $display("FAIL zero_flags: got %b want 00", {flag_ovf, flag_unf}); end
      wb_ready = 1'b1; step(); wb_ready = 1'b0; exp_ret = exp_ret + 16'd1;
      // zero beats an overflow indication
      drive(1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 5'd10);
      step();
      idle();
      checks++; if (wb_data !== 32'h00000000) begin errors++; $display("FAIL zero_prio_data: got %h want 00000000", wb_data); end
      checks++; if (flag_ovf !== 1'b0) begin errors++; $display("FAIL zero_prio_flag: got %0b want 0", flag_ovf); end
      wb_ready = 1'b1; step(); wb_ready = 1'b0; exp_ret = exp_ret + 16'd1;
      // overflow to +infinity
      drive(1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0, 5'd11);
      step();
      idle();
      checks++; if (wb_data !== 32'h7F800000) begin errors++; $display("FAIL ovf_data: got %h want 7f800000", wb_data); end
      checks++; if (flag_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", flag_ovf); end
      checks++; if (flag_unf !== 1'b0) begin errors++; $display("FAIL ovf_unf_clear: got %0b want 0", flag_unf); end
      wb_ready = 1'b1; step(); wb_ready = 1'b0; exp_ret = exp_ret + 16'd1;
      checks++; if (flag_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", flag_ovf); end
      flag_clr = 1'b1; step(); flag_clr = 1'b0;
      checks++; if (flag_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b want 0", flag_ovf); end
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL fixup_retired: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_backpressure();
      wb_ready = 1'b0;
      drive(1'b1, 32'h3F800001, 1'b0, 1'b0, 1'b0, 5'd1);
      step();
      drive(1'b1, 32'h3F800002, 1'b0, 1'b0, 1'b0, 5'd2);
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %0b want 0", in_ready); end
      drive(1'b1, 32'h3F800007, 1'b0, 1'b0, 1'b0, 5'd7);
      step();
      idle();
      checks++; if (wb_rd !== 5'd1) begin errors++; $display("FAIL bp_hold_rd: got %0d want 1", wb_rd); end
      checks++; if (wb_data !== 32'h3F800001) begin errors++; $display("FAIL bp_hold_data: got %h want 3f800001", wb_data); end
      wb_ready = 1'b1;
      step();
      exp_ret = exp_ret + 16'd1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %0b want 1", in_ready); end
      checks++; if (wb_rd !== 5'd2) begin errors++; $display("FAIL bp_second_rd: got %0d want 2", wb_rd); end
      checks++; if (wb_data !== 32'h3F800002) begin errors++; $display("FAIL bp_second_data: got %h want 3f800002", wb_data); end
      step();
      exp_ret = exp_ret + 16'd1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bp_third_dropped: got %0b want 0", wb_valid); end
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL bp_retired: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_simultaneous();
      wb_ready = 1'b0;
      drive(1'b1, 32'h40000004, 1'b0, 1'b0, 1'b0, 5'd4);
      step();
      wb_ready = 1'b1;
      drive(1'b1, 32'h40000005, 1'b0, 1'b0, 1'b0, 5'd5);
      step();
      idle();
      exp_ret = exp_ret + 16'd1;
      checks++; if ({wb_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL simul_count1: got %b want 11", {wb_valid, in_ready}); end
      checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL simul_order: got %0d want 5", wb_rd); end
      step();
      exp_ret = exp_ret + 16'd1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL simul_drained: got %0b want 0", wb_valid); end
      // clear and underflow set in the same cycle: set wins
      flag_clr = 1'b1;
      drive(1'b1, 32'h80001234, 1'b1, 1'b0, 1'b0, 5'd6);
      step();
      flag_clr = 1'b0;
      idle();
      checks++; if (flag_unf !== 1'b1) begin errors++; $display("FAIL clr_vs_set: got %0b want 1", flag_unf); end
      checks++; if (wb_data !== 32'h80000000) begin errors++; $display("FAIL unf_data: got %h want 80000000", wb_data); end
      step();
      exp_ret = exp_ret + 16'd1;
   endtask

   task automatic test_ptr_wrap();
      logic [31:0] v;
      wb_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         v = 32'h41000000 + 32'(i);
         drive(1'b1, v, 1'b0, 1'b0, 1'b0, 5'(i + 16));
         step();
         if (i > 0) exp_ret = exp_ret + 16'd1;
         checks++; if (wb_data !== v) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, wb_data, v); end
         checks++; if (wb_rd !== 5'(i + 16)) begin errors++; $display("FAIL wrap_rd[%0d]: got %0d want %0d", i, wb_rd, i + 16); end
      end
      idle();
      step();
      exp_ret = exp_ret + 16'd1;
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL wrap_retired: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_retired_wrap();
      int n;
      n = 65535 - int'(exp_ret);
      wb_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, 5'd0);
         step();
      end
      idle();
      step();
      checks++; if (retired !== 16'hFFFF) begin errors++; $display("FAIL ret_preset: got %h want ffff", retired); end
      drive(1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, 5'd1);
      step();
      idle();
      step();
      checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL ret_wrap: got %h want 0000", retired); end
      exp_ret = 16'd0;
   endtask

   task automatic test_async_reset();
      wb_ready = 1'b0;
      drive(1'b1, 32'h00000001, 1'b1, 1'b1, 1'b0, 5'd12);
      step();
      drive(1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 5'd13);
      step();
      idle();
      checks++; if ({flag_ovf, flag_unf, in_ready} !== 3'b110) begin errors++; $display("FAIL arst_setup: got %b want 110", {flag_ovf, flag_unf, in_ready}); end
      #2 reset = 1'b1;
      #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b want 0", wb_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %0b want 1", in_ready); end
      checks++; if ({flag_ovf, flag_unf} !== 2'b00) begin errors++; $display("FAIL arst_flags: got %b want 00", {flag_ovf, flag_unf}); end
      checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL arst_data: got %h want 0", wb_data); end
      #1 reset = 1'b0;
      drive(1'b1, 32'hC0490FDB, 1'b0, 1'b0, 1'b0, 5'd31);
      step();
      idle();
      checks++; if (wb_data !== 32'hC0490FDB) begin errors++; $display("FAIL arst_new_data: got %h want c0490fdb", wb_data); end
      checks++; if (wb_rd !== 5'd31) begin errors++; $display("FAIL arst_new_rd: got %0d want 31", wb_rd); end
      wb_ready = 1'b1;
      step();
      checks++; if ({wb_valid, retired} !== {1'b0, 16'd1}) begin errors++; $display("FAIL arst_one_pop: got %b/%0d want 0/1", wb_valid, retired); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      exp_ret = 16'd0;
      reset = 1'b0;
      wb_ready = 1'b0;
      flag_clr = 1'b0;
      idle();
      test_reset();
      test_normal();
      test_fixups();
      test_backpressure();
      test_simultaneous();
      test_ptr_wrap();
      test_retired_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
